// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, storage types and controller states for mem_responder.
package mem_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef enum logic {CLEAR, IDLE} mem_state_t;
endpackage

// File: rtl/rd_pipe.sv
// rd_pipe: valid+data shift register; data stages load only on valid so the last stage holds the last result.
module rd_pipe #(
  parameter int STAGES = 1,
  parameter int W      = 8
) (
  input  logic         clk,
  input  logic         flush,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  output logic         valid_out,
  output logic [W-1:0] data_out
);
  logic [STAGES-1:0] v;
  logic [W-1:0]      d [STAGES];
  always_ff @(posedge clk) begin
    if (flush) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= '0;
    end else begin
      v[0] <= valid_in;
      if (valid_in) d[0] <= data_in;
      for (int i = 1; i < STAGES; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end
  assign valid_out = v[STAGES-1];
  assign data_out  = d[STAGES-1];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: 32x8 strobe memory with post-reset clear sweep, pipelined reads and saturating access counters.
module mem_responder
  import mem_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  addr_t       addr,
  input  data_t       data_in,
  output data_t       data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        err,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("mem_responder: RD_LATENCY must be in 1..4");
  end
  mem_state_t state, state_next;
  addr_t      ptr;
  data_t      mem [DEPTH];
  logic       idle, wr_acc, rd_acc, bad;
  assign idle   = state == IDLE;
  assign busy   = !idle;
  assign wr_acc = idle && write && !read;
  assign rd_acc = idle && read && !write;
  assign bad    = (read && write) || (!idle && (read || write));
  always_comb begin
    state_next = CLEAR;
    state_next = state == CLEAR ? (ptr == addr_t'(DEPTH - 1) ? IDLE : CLEAR)
               : state == IDLE  ? IDLE : CLEAR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      ptr      <= '0;
      err      <= 1'b0;
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      state <= state_next;
      ptr   <= idle ? '0 : ptr + 1'b1;
      err   <= bad;
      if (wr_acc && wr_count != 16'hFFFF) wr_count <= wr_count + 1'b1;
      if (rd_acc && rd_count != 16'hFFFF) rd_count <= rd_count + 1'b1;
    end
  end
  // Clear sweep owns the array until it finishes, so it never competes with a write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!idle) mem[ptr] <= '0;
      else if (wr_acc) mem[addr] <= data_in;
    end
  end
  rd_pipe #(.STAGES(RD_LATENCY), .W(DATA_W)) u_rd_pipe (
    .clk      (clk),
    .flush    (rst),
    .valid_in (rd_acc),
    .data_in  (mem[addr]),
    .valid_out(data_valid),
    .data_out (data_out)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three latencies driven in lockstep, checked against a cycle-indexed behavioural model.
module tb_mem_responder;
  import mem_pkg::*;
  localparam int NC = 2048;
  localparam int LAT [3] = '{1, 3, 4};
  logic clk = 0, rst = 0, read = 0, write = 0;
  addr_t addr = '0;
  data_t data_in = '0;
  data_t dout [3];
  logic dv [3], bsy [3], er [3];
  logic [15:0] wrc [3], rdc [3];
  int checks = 0, failures = 0;
  int mem_m [32];
  int clear_left = 0, wrc_m = 0, rdc_m = 0, t = 0, rst_edge = -1;
  bit err_m = 0;
  bit hv [NC];
  int hd [NC];
  int last_out [3];
  bit exp_v [3];
  int busy_cycles = 0, dv4_pulses = 0;

  always #5 clk = ~clk;

  mem_responder #(.RD_LATENCY(1)) u1 (.clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(dout[0]), .data_valid(dv[0]), .busy(bsy[0]), .err(er[0]),
    .wr_count(wrc[0]), .rd_count(rdc[0]));
  mem_responder #(.RD_LATENCY(3)) u3 (.clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(dout[1]), .data_valid(dv[1]), .busy(bsy[1]), .err(er[1]),
    .wr_count(wrc[1]), .rd_count(rdc[1]));
  mem_responder #(.RD_LATENCY(4)) u4 (.clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(dout[2]), .data_valid(dv[2]), .busy(bsy[2]), .err(er[2]),
    .wr_count(wrc[2]), .rd_count(rdc[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  // Reference: a read accepted at edge k shows up after edge k+L-1 unless a reset edge intervenes.
  task automatic model(input bit rs, input bit r, input bit w, input int a, input int d);
    hv[t] = 0;
    if (rs) begin
      clear_left = 32; wrc_m = 0; rdc_m = 0; err_m = 0; rst_edge = t;
      for (int k = 0; k < 3; k++) begin last_out[k] = 0; exp_v[k] = 0; end
    end else begin
      err_m = (clear_left > 0 && (r || w)) || (r && w);
      if (clear_left > 0) begin
        mem_m[32 - clear_left] = 0;
        clear_left--;
      end else if (w && !r) begin
        mem_m[a] = d;
        if (wrc_m < 65535) wrc_m++;
      end else if (r && !w) begin
        hv[t] = 1; hd[t] = mem_m[a];
        if (rdc_m < 65535) rdc_m++;
      end
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = t - LAT[k] + 1;
        exp_v[k] = idx > rst_edge && hv[idx];
        if (exp_v[k]) last_out[k] = hd[idx];
      end
    end
    t++;
  endtask

  task automatic step(input bit r, input bit w, input int a, input int d, input bit rs = 0);
    @(negedge clk);
    rst = rs; read = r; write = w; addr = addr_t'(a); data_in = data_t'(d);
    @(posedge clk);
    model(rs, r, w, a, d);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("busy_L%0d", LAT[k]), 32'(bsy[k]), 32'(clear_left > 0));
      check($sformatf("err_L%0d", LAT[k]), 32'(er[k]), 32'(err_m));
      check($sformatf("wr_count_L%0d", LAT[k]), 32'(wrc[k]), 32'(wrc_m));
      check($sformatf("rd_count_L%0d", LAT[k]), 32'(rdc[k]), 32'(rdc_m));
      check($sformatf("valid_L%0d", LAT[k]), 32'(dv[k]), 32'(exp_v[k]));
      check($sformatf("data_out_L%0d", LAT[k]), 32'(dout[k]), 32'(last_out[k]));
    end
    if (bsy[0] === 1'b1) busy_cycles++;
    if (dv[2] === 1'b1) dv4_pulses++;
  endtask

  initial begin
    busy_cycles = 0;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 34; i++) step(i == 3, 0, 9, 0);
    check("busy_len_after_reset", busy_cycles, 32);
    for (int i = 0; i < 32; i++) step(1, 0, i, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("rd_count_after_zero_sweep", 32'(rdc[0]), 32);
    step(1, 1, 7, 8'h5A);
    step(0, 0, 0, 0);
    step(1, 0, 7, 0);
    step(0, 0, 0, 0);
    check("mem7_after_conflict", 32'(dout[0]), 0);
    step(0, 1, 5, 8'hA5);
    step(1, 0, 5, 0);
    check("raw_read_addr5", 32'(dout[0]), 8'hA5);
    check("raw_read_valid", 32'(dv[0]), 1);
    for (int i = 0; i < 32; i++) step(0, 1, i, i ^ 8'h3C);
    for (int i = 0; i < 32; i++) step(1, 0, i, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("last_burst_data_L3", 32'(dout[1]), 31 ^ 8'h3C);
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      step(sel < 4 || sel == 9, sel >= 4 && sel != 8, int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    dv4_pulses = 0;
    step(1, 0, 1, 0);
    step(1, 0, 2, 0);
    step(0, 0, 0, 0);
    busy_cycles = 0;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 36; i++) step(0, 0, 0, 0);
    check("no_valid_after_abort_L4", dv4_pulses, 0);
    check("busy_len_after_abort", busy_cycles, 32);
    check("wr_count_after_abort", 32'(wrc[0]), 0);
    check("rd_count_after_abort", 32'(rdc[0]), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 5-bit address / 8-bit data read/write strobe interface used by the Chp6 testbenches.
- Holds a 32x8 storage array. Writes commit on the clock edge where they are sampled. Reads return data after a fixed, parameterised pipeline latency with a data_valid qualifier.
- After reset, a clear sequencer zeroes the array before any access is accepted.
- Flags protocol violations and keeps saturating access counters for testbench scoreboarding.

Parameters:
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W = 32.
- DATA_W, 8, data width.
- RD_LATENCY, 1, cycles from sampled read to data_valid. Legal range 1..4; elaboration error outside this range.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- read  in  1  read strobe, sampled every edge.
- write  in  1  write strobe, sampled every edge.
- addr  in  ADDR_W  access address.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data; holds the last returned value.
- data_valid  out  1  one-cycle pulse per completed read.
- busy  out  1  high while the clear sequencer runs.
- err  out  1  one-cycle pulse on a rejected access.
- wr_count  out  16  accepted writes, saturating at 16'hFFFF.
- rd_count  out  16  accepted reads, saturating at 16'hFFFF.

Behaviour:
- Reset is synchronous and active-high on clk. While rst=1:
  - state <= CLEAR, clear pointer <= 0.
  - data_out <= 0, data_valid <= 0, err <= 0, busy <= 1.
  - wr_count <= 0, rd_count <= 0.
  - Read pipeline flushed (all valid stages cleared).
  - Array contents are not reset directly; the clear sequencer zeroes them.
- State machine (enum in package):
  - CLEAR: writes 0 to mem[ptr] each cycle and increments ptr. At ptr == DEPTH-1, the write completes and the next state is IDLE. Duration is exactly 32 cycles after rst deasserts. busy = 1 throughout.
  - IDLE: busy = 0; accepts accesses.
  - No other states. An illegal state encoding goes to CLEAR.
- Access decode, IDLE only, sampled at edge N:
  - write=1, read=0: mem[addr] <= data_in at edge N; wr_count++.
  - read=1, write=0: mem[addr] is captured into pipeline stage 0 at edge N; rd_count++. data_out and data_valid update at edge N+RD_LATENCY-1, so they are visible in the cycle after edge N+RD_LATENCY-1. RD_LATENCY=1 means data appears on the cycle immediately after the read cycle.
  - read=1, write=1: no memory change, no counter change, err=1 next cycle.
  - In CLEAR, any read or write: ignored, err=1 next cycle.
- Ordering and hazards:
  - A read at edge N+1 of the address written at edge N returns the new data.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
- Output holding: data_out holds its value when data_valid=0. data_valid is never high for more than one cycle per read.
- Counters saturate; they do not wrap.
- Reset mid-operation: in-flight reads are discarded with no data_valid. The clear sequencer restarts at address 0.
- Address is full-range (0..31), so no out-of-range case exists.

Decomposition:
- Package mem_pkg:
  - ADDR_W, DATA_W, and DEPTH localparams.
  - typedef logic [ADDR_W-1:0] addr_t and typedef logic [DATA_W-1:0] data_t.
  - typedef enum logic {CLEAR, IDLE} mem_state_t.
- Sub-module rd_pipe: parameterised RD_LATENCY-stage valid+data shift register with synchronous flush, instantiated once.

Test Plan:
- Reset, then hold read=write=0 -> busy high for exactly 32 cycles, then 0. A read of every address 0..31 returns 8'h00. rd_count = 32.
- Write addr 5 = 8'hA5, next cycle read addr 5 (RD_LATENCY=1) -> data_out = 8'hA5 with data_valid one cycle after the read cycle. wr_count = 1.
- Write 0..31 with data = addr^8'h3C, then 32 back-to-back reads at RD_LATENCY=3 -> 32 consecutive data_valid pulses in address order. The first pulse arrives 3 cycles after the first read.
- read=write=1 at addr 7 in IDLE -> err pulses once. mem[7] unchanged (read back 8'h00). Counters unchanged.
- Read issued while busy=1 -> err pulses, no data_valid, rd_count stays 0.
- Issue reads to addrs 1,2 at RD_LATENCY=4, assert rst 2 cycles later -> no data_valid ever fires. busy reasserts for 32 cycles and counters read 0.
